// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and driver state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned ALU_OP_W  = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_EQ  = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the external combinational ALU: accumulator, repeat counter, response port.
// Optional sticky carry/borrow output enabled by defining ALU_CMD_DRIVER_CARRY_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OP_W  = ALU_OP_W,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_load,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_CMD_DRIVER_CARRY_EN
  output logic             rsp_carry,
`endif
  output logic             rsp_flag
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] imm_q;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt_q;

  // The ALU always sees the live accumulator and the latched command.
  assign alu_a    = acc;
  assign alu_b    = imm_q;
  assign alu_sel  = op_q;
  assign rsp_data = acc;

`ifdef ALU_CMD_DRIVER_CARRY_EN
  logic [WIDTH:0] add_ext;
  logic           step_carry;

  // Carry/borrow produced by the current EXEC step, derived from the operands.
  always_comb begin
    add_ext    = {1'b0, acc} + {1'b0, imm_q};
    step_carry = 1'b0;
    case (op_q)
      OP_W'(OP_ADD): step_carry = add_ext[WIDTH];
      OP_W'(OP_SUB): step_carry = (imm_q > acc);
      OP_W'(OP_SHL): step_carry = acc[WIDTH-1];
      OP_W'(OP_SHR): step_carry = acc[0];
      default:       step_carry = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_flag  <= 1'b0;
`ifdef ALU_CMD_DRIVER_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
`ifdef ALU_CMD_DRIVER_CARRY_EN
            rsp_carry <= 1'b0;
`endif
            if (cmd_load) begin
              acc       <= cmd_imm;
              rsp_flag  <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              op_q  <= cmd_op;
              imm_q <= cmd_imm;
              cnt_q <= cmd_cnt;
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc <= alu_r;
`ifdef ALU_CMD_DRIVER_CARRY_EN
          rsp_carry <= rsp_carry | step_carry;
`endif
          if (cnt_q == '0) begin
            rsp_flag  <= alu_flag;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural ALU and a reference accumulator model.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int unsigned WIDTH = ALU_WIDTH;
  localparam int unsigned OP_W  = ALU_OP_W;
  localparam int unsigned CNT_W = 2;
  localparam int MODV = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_load;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_imm;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [OP_W-1:0]  alu_sel;
  logic             alu_flag;
  logic             rsp_valid, rsp_ready, rsp_flag;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_CMD_DRIVER_CARRY_EN
  logic             rsp_carry;
`endif

  int errors = 0;
  int checks = 0;
  int m_acc = 0, m_flag = 0, m_carry = 0;

  alu_cmd_driver #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_imm(cmd_imm), .cmd_load(cmd_load), .cmd_cnt(cmd_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_r(alu_r), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_CMD_DRIVER_CARRY_EN
    .rsp_carry(rsp_carry),
`endif
    .rsp_flag(rsp_flag)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational ALU.
  always_comb begin
    case (alu_sel)
      3'd0: alu_r = alu_a + alu_b;
      3'd1: alu_r = alu_a - alu_b;
      3'd2: alu_r = alu_a & alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = alu_a ^ alu_b;
      3'd5: alu_r = (alu_a == alu_b) ? WIDTH'(1) : WIDTH'(0);
      3'd6: alu_r = alu_a << 1;
      default: alu_r = alu_a >> 1;
    endcase
    alu_flag = (alu_a > alu_b);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: apply the op cnt+1 times to the integer accumulator.
  task automatic model_exec(input int op, input int imm, input int cnt);
    int a, r;
    m_carry = 0;
    for (int i = 0; i <= cnt; i++) begin
      a = m_acc;
      case (op)
        0: begin r = (a + imm) % MODV; if (a + imm >= MODV) m_carry = 1; end
        1: begin r = (a - imm + MODV) % MODV; if (imm > a) m_carry = 1; end
        2: r = a & imm;
        3: r = a | imm;
        4: r = a ^ imm;
        5: r = (a == imm) ? 1 : 0;
        6: begin r = (a * 2) % MODV; if (a >= MODV / 2) m_carry = 1; end
        default: begin r = a / 2; if (a % 2 == 1) m_carry = 1; end
      endcase
      m_flag = (a > imm) ? 1 : 0;
      m_acc = r;
    end
  endtask

  task automatic drive_noise();
    cmd_valid = 1'b1;
    cmd_load  = 1'($urandom);
    cmd_op    = OP_W'($urandom);
    cmd_imm   = WIDTH'($urandom);
    cmd_cnt   = CNT_W'($urandom);
  endtask

  // Issue one command at a negedge, check latency, the response, and the stall behaviour.
  task automatic run_cmd(input bit load, input int op, input int imm, input int cnt, input int stall);
    int lat, j;
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_op    = OP_W'(op);
    cmd_imm   = WIDTH'(imm);
    cmd_cnt   = CNT_W'(cnt);
    check("cmd_ready_idle", int'(cmd_ready), 1);
    @(posedge clk);
    if (load) begin
      m_acc = imm; m_flag = 0; m_carry = 0; lat = 1;
    end else begin
      model_exec(op, imm, cnt); lat = cnt + 2;
    end
    @(negedge clk);
    drive_noise();
    j = 0;
    while (!rsp_valid && j < 20) begin
      check("cmd_ready_busy", int'(cmd_ready), 0);
      @(negedge clk);
      j++;
    end
    check("latency", j, lat - 1);
    check("rsp_data", int'(rsp_data), m_acc);
    check("rsp_flag", int'(rsp_flag), m_flag);
`ifdef ALU_CMD_DRIVER_CARRY_EN
    check("rsp_carry", int'(rsp_carry), m_carry);
`endif
    for (int s = 0; s < stall; s++) begin
      drive_noise();
      @(negedge clk);
      check("stall_valid", int'(rsp_valid), 1);
      check("stall_data", int'(rsp_data), m_acc);
      check("stall_ready", int'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_valid", int'(rsp_valid), 0);
    check("post_ready", int'(cmd_ready), 1);
    check("post_acc", int'(alu_a), m_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_imm = '0;
    cmd_cnt = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_flag", int'(rsp_flag), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_sel", int'(alu_sel), 0);

    // Directed scenarios.
    run_cmd(1, 0, 5, 0, 0);
    run_cmd(0, 0, 3, 0, 0);
    check("add_5_3", int'(rsp_data), 8);
    run_cmd(1, 0, 1, 0, 0);
    run_cmd(0, 6, 0, 2, 0);
    check("shl_x3", m_acc, 8);
    run_cmd(1, 0, 15, 0, 0);
    run_cmd(0, 0, 1, 0, 0);
    run_cmd(0, 1, 1, 0, 0);
    run_cmd(1, 0, 6, 0, 0);
    run_cmd(0, 5, 6, 0, 0);
    run_cmd(0, 5, 2, 0, 5);

    // Reset in the middle of a cnt=3 op aborts it with no response.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_W'(0); cmd_imm = WIDTH'(3); cmd_cnt = CNT_W'(3);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(rsp_valid), 0);
    check("mid_rst_acc", int'(alu_a), 0);
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_sel", int'(alu_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0;
    repeat (5) begin
      @(negedge clk);
      check("after_rst_valid", int'(rsp_valid), 0);
    end
    run_cmd(1, 0, 9, 0, 0);

    // Randomized commands against the model.
    for (int n = 0; n < 60; n++) begin
      run_cmd(($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, MODV - 1),
              $urandom_range(0, (1 << CNT_W) - 1), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
